// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage RV32E pipeline.
//
// Tracks the destination registers of instructions in EX/MEM/WB and detects
// read-after-write hazards against the instruction in ID. There is no
// forwarding, so every match stalls. Taken branches from EX squash the next
// FLUSH_DEPTH ID slots. An outstanding data-memory access freezes the pipe.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   valid_ID            ID holds a real instruction
//   rs1_ID, rs2_ID      source registers of the instruction in ID
//   rs1_used_ID/rs2_... source actually read
//   rd_ID               destination register of the instruction in ID
//   regfile_we_ID       instruction writes rd
//   branch_taken_EX     redirect resolved in EX this cycle
//   mem_req_MEM         MEM holds a load or store
//   mem_ready           data memory completes the access this cycle
//   stall               hold IF/ID and PC; ID/EX takes a bubble
//   invalid_ID          ID is wrong-path; ID/EX takes a bubble
//   freeze              hold every pipeline register
//   stall_cycles        saturating count of cycles with stall or freeze
module pipeline_hazard_controller #(
  parameter int unsigned PENDING_STAGES = 3,
  parameter int unsigned FLUSH_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_ID,
  input  logic [3:0]  rs1_ID,
  input  logic [3:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [3:0]  rd_ID,
  input  logic        regfile_we_ID,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready,
  output logic        stall,
  output logic        invalid_ID,
  output logic        freeze,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CntW = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam logic [CntW-1:0] FlushLoad = CntW'(FLUSH_DEPTH - 1);

  typedef enum logic [1:0] {StRun, StFlush, StMemWait} state_e;

  state_e                             state_q, state_d;
  state_e                             saved_q, saved_d;
  logic [CntW-1:0]                    cnt_q, cnt_d;
  logic [PENDING_STAGES-1:0]          sb_valid_q, sb_valid_d;
  logic [PENDING_STAGES-1:0][3:0]     sb_rd_q, sb_rd_d;
  logic [31:0]                        stall_cycles_q, stall_cycles_d;

  logic rs1_hit, rs2_hit, raw, mem_stall, issue;

  // RAW detection against every valid in-flight destination.
  always_comb begin
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned i = 0; i < PENDING_STAGES; i++) begin
      if (sb_valid_q[i] && (sb_rd_q[i] == rs1_ID)) rs1_hit = 1'b1;
      if (sb_valid_q[i] && (sb_rd_q[i] == rs2_ID)) rs2_hit = 1'b1;
    end
    raw = valid_ID & ((rs1_used_ID & (rs1_ID != 4'd0) & rs1_hit) |
                      (rs2_used_ID & (rs2_ID != 4'd0) & rs2_hit));
  end

  always_comb begin
    mem_stall  = mem_req_MEM & ~mem_ready;
    freeze     = (state_q == StMemWait) | mem_stall;
    invalid_ID = branch_taken_EX | (cnt_q != '0);
    // Wrong-path slots never stall so the redirect always proceeds.
    stall      = (raw | freeze) & ~invalid_ID;
    issue      = valid_ID & ~stall & ~invalid_ID & regfile_we_ID & (rd_ID != 4'd0);
  end

  // Scoreboard shifts toward WB on every unfrozen cycle.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_rd_d    = sb_rd_q;
    if (!freeze) begin
      for (int unsigned i = 1; i < PENDING_STAGES; i++) begin
        sb_valid_d[i] = sb_valid_q[i-1];
        sb_rd_d[i]    = sb_rd_q[i-1];
      end
      sb_valid_d[0] = issue;
      sb_rd_d[0]    = issue ? rd_ID : 4'd0;
    end
  end

  // Sequencer: a memory wait dominates; branches seen while frozen are
  // held by EX and acted on at the first unfrozen cycle.
  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StRun, StFlush: begin
        if (mem_stall) begin
          saved_d = state_q;
          state_d = StMemWait;
        end else if (branch_taken_EX) begin
          cnt_d   = FlushLoad;
          state_d = (FLUSH_DEPTH > 1) ? StFlush : StRun;
        end else if (state_q == StFlush) begin
          cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
          if (cnt_d == '0) state_d = StRun;
        end
      end
      StMemWait: begin
        if (mem_ready) state_d = saved_q;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stall | freeze) && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      saved_q        <= StRun;
      cnt_q          <= '0;
      sb_valid_q     <= '0;
      sb_rd_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      saved_q        <= saved_d;
      cnt_q          <= cnt_d;
      sb_valid_q     <= sb_valid_d;
      sb_rd_q        <= sb_rd_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_pipeline_hazard_controller;

  localparam int P = 3;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_ID, rs1_used_ID, rs2_used_ID, regfile_we_ID;
  logic [3:0]  rs1_ID, rs2_ID, rd_ID;
  logic        branch_taken_EX, mem_req_MEM, mem_ready;
  logic        stall, invalid_ID, freeze;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Model state: pending destinations (0 = empty slot), remaining flush
  // slots after the current one, memory-wait flag, stall counter.
  int          pend[P];
  int          m_flush;
  bit          m_wait;
  longint      m_cnt;
  bit          e_stall, e_inv, e_frz;

  pipeline_hazard_controller #(.PENDING_STAGES(P), .FLUSH_DEPTH(D)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_ID        (valid_ID),
    .rs1_ID          (rs1_ID),
    .rs2_ID          (rs2_ID),
    .rs1_used_ID     (rs1_used_ID),
    .rs2_used_ID     (rs2_used_ID),
    .rd_ID           (rd_ID),
    .regfile_we_ID   (regfile_we_ID),
    .branch_taken_EX (branch_taken_EX),
    .mem_req_MEM     (mem_req_MEM),
    .mem_ready       (mem_ready),
    .stall           (stall),
    .invalid_ID      (invalid_ID),
    .freeze          (freeze),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < P; i++) pend[i] = 0;
    m_flush = 0;
    m_wait  = 1'b0;
    m_cnt   = 0;
  endtask

  task automatic model_eval();
    bit hit1, hit2, raw;
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < P; i++) begin
      if (pend[i] != 0 && pend[i] == int'(rs1_ID)) hit1 = 1'b1;
      if (pend[i] != 0 && pend[i] == int'(rs2_ID)) hit2 = 1'b1;
    end
    raw     = valid_ID && ((rs1_used_ID && hit1) || (rs2_used_ID && hit2));
    e_frz   = m_wait || (mem_req_MEM && !mem_ready);
    e_inv   = branch_taken_EX || (m_flush > 0);
    e_stall = (raw || e_frz) && !e_inv;
  endtask

  // Advance one clock edge, updating the model with the inputs of that cycle.
  task automatic tick();
    bit iss;
    @(posedge clk);
    model_eval();
    if ((e_stall || e_frz) && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    if (!e_frz) begin
      iss = valid_ID && !e_stall && !e_inv && regfile_we_ID && rd_ID != 4'd0;
      for (int i = P - 1; i > 0; i--) pend[i] = pend[i-1];
      pend[0] = iss ? int'(rd_ID) : 0;
      if (branch_taken_EX) m_flush = D - 1;
      else if (m_flush > 0) m_flush--;
    end
    if (m_wait) m_wait = !mem_ready;
    else        m_wait = mem_req_MEM && !mem_ready;
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] r1, input logic u1,
                       input logic [3:0] r2, input logic u2, input logic [3:0] rd,
                       input logic we, input logic br, input logic req, input logic rdy);
    valid_ID = v; rs1_ID = r1; rs1_used_ID = u1; rs2_ID = r2; rs2_used_ID = u2;
    rd_ID = rd; regfile_we_ID = we; branch_taken_EX = br; mem_req_MEM = req;
    mem_ready = rdy;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #2;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (invalid_ID !== 1'b0) begin errors++; $display("FAIL reset_inv got %b want 0", invalid_ID); end
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b want 0", freeze); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", stall_cycles); end
    do_reset();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_first got %b want 0", stall); end
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (stall !== (k < 3)) begin errors++; $display("FAIL lu_stall[%0d] got %b want %b", k, stall, k < 3); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (stall_cycles !== 32'd3) begin errors++; $display("FAIL lu_cnt got %0d want 3", stall_cycles); end
    tick();
  endtask

  task automatic test_r0_unused();
    logic [3:0] r1v[4], r2v[4], rdv[4];
    logic       u2v[4], wev[4];
    do_reset();
    r1v = '{0, 0, 0, 0}; r2v = '{0, 0, 0, 5}; rdv = '{0, 0, 5, 0};
    u2v = '{0, 1, 0, 0}; wev = '{1, 0, 1, 0};
    for (int k = 0; k < 4; k++) begin
      drive(1, r1v[k], 1, r2v[k], u2v[k], rdv[k], wev[k], 0, 0, 0);
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall[%0d] got %b want 0", k, stall); end
      tick();
    end
  endtask

  task automatic test_branch_hazard();
    logic [4:0] e_i, e_s;
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    e_i = 5'b00011;  // bit k = cycle k after the writer
    e_s = 5'b00100;
    for (int k = 0; k < 5; k++) begin
      drive(1, 5, 1, 0, 0, 0, 0, (k == 0), 0, 0);
      @(negedge clk);
      checks++;
      if (invalid_ID !== e_i[k]) begin errors++; $display("FAIL br_inv[%0d] got %b want %b", k, invalid_ID, e_i[k]); end
      checks++;
      if (stall !== e_s[k]) begin errors++; $display("FAIL br_stall[%0d] got %b want %b", k, stall, e_s[k]); end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    for (int k = 1; k <= 9; k++) begin
      drive(1, 5, 1, 0, 0, 0, 0, 0, (k <= 5), (k == 5));
      @(negedge clk);
      checks++;
      if (freeze !== (k <= 5)) begin errors++; $display("FAIL mw_freeze[%0d] got %b want %b", k, freeze, k <= 5); end
      checks++;
      if (stall !== (k <= 8)) begin errors++; $display("FAIL mw_stall[%0d] got %b want %b", k, stall, k <= 8); end
      if (k == 6) begin
        checks++;
        if (stall_cycles !== 32'd5) begin errors++; $display("FAIL mw_cnt got %0d want 5", stall_cycles); end
      end
      tick();
    end
  endtask

  task automatic test_branch_in_wait();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, (k <= 4), (k <= 3), (k == 3));
      @(negedge clk);
      checks++;
      if (freeze !== (k <= 3)) begin errors++; $display("FAIL bw_freeze[%0d] got %b want %b", k, freeze, k <= 3); end
      checks++;
      if (invalid_ID !== (k <= 5)) begin errors++; $display("FAIL bw_inv[%0d] got %b want %b", k, invalid_ID, k <= 5); end
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL bw_stall[%0d] got %b want 0", k, stall); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    // Mid-flush with x5 in flight.
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (invalid_ID !== 1'b1) begin errors++; $display("FAIL ar_preflush got %b want 1", invalid_ID); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (invalid_ID !== 1'b0) begin errors++; $display("FAIL ar_flush_inv got %b want 0", invalid_ID); end
    rst_n = 1'b1;
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ar_flush_sb got %b want 0", stall); end
    tick();
    // Mid memory wait.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL ar_prewait got %b want 1", freeze); end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL ar_wait_freeze got %b want 0", freeze); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL ar_wait_cnt got %0d want 0", stall_cycles); end
    rst_n = 1'b1;
    tick();
    drive(1, 3, 1, 0, 0, 3, 1, 0, 0, 0);
    @(negedge clk);
    checks++; if ((freeze | stall) !== 1'b0) begin errors++; $display("FAIL ar_wait_issue got %b want 0", freeze | stall); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
      model_eval();
      @(negedge clk);
      checks++;
      if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %b want %b", n, stall, e_stall); end
      checks++;
      if (invalid_ID !== e_inv) begin errors++; $display("FAIL rnd_inv[%0d] got %b want %b", n, invalid_ID, e_inv); end
      checks++;
      if (freeze !== e_frz) begin errors++; $display("FAIL rnd_freeze[%0d] got %b want %b", n, freeze, e_frz); end
      checks++;
      if (stall_cycles !== 32'(m_cnt)) begin
        errors++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", n, stall_cycles, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_r0_unused();
    test_branch_hazard();
    test_mem_wait();
    test_branch_in_wait();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
